// File: rtl/gray_in_decoder_if.sv
// Pin-side bundle for the Gray-code receiver: raw encoder pins in, decoded
// value, step/error pulses and the running position out.
interface gray_in_decoder_if #(
  parameter int BITS  = 5,
  parameter int POS_W = 16
);
  logic [BITS-1:0]  GRAY_IN;
  logic [BITS-1:0]  VALUE;
  logic             VALID;
  logic             STEP;
  logic             DIR;
  logic             ERR;
  logic [POS_W-1:0] POSITION;

  modport master (
    output GRAY_IN,
    input  VALUE, VALID, STEP, DIR, ERR, POSITION
  );

  modport slave (
    input  GRAY_IN,
    output VALUE, VALID, STEP, DIR, ERR, POSITION
  );
endinterface

// File: rtl/gray_in_decoder.sv
// Receives an asynchronous reflected-Gray code, synchronizes and debounces it,
// converts to binary and tracks +1/-1 steps into a signed position counter.
//
// state    | meaning
// ST_INIT  | waiting for the first stable code after reset; no steps reported
// ST_TRACK | VALUE holds a reference code; each accepted change is classified
module gray_in_decoder #(
  parameter int BITS      = 5,
  parameter int FILT_LOG2 = 4,
  parameter int POS_W     = 16
) (
  input logic              CLK,
  input logic              RST,
  gray_in_decoder_if.slave bus
);

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  localparam logic [FILT_LOG2-1:0] CNT_MAX  = {FILT_LOG2{1'b1}};
  localparam logic [BITS-1:0]      DELTA_UP = BITS'(1);
  localparam logic [BITS-1:0]      DELTA_DN = {BITS{1'b1}};

  function automatic logic [BITS-1:0] gray2bin(input logic [BITS-1:0] g);
    logic [BITS-1:0] b;
    b = '0;
    b[BITS-1] = g[BITS-1];
    for (int i = BITS - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [BITS-1:0]      sync_1;
  logic [BITS-1:0]      sync_s;
  logic [2:0]           sync_fill;
  logic [BITS-1:0]      cand;
  logic [FILT_LOG2-1:0] cnt;
  logic                 fired;
  logic                 accept;
  logic                 load;
  logic [BITS-1:0]      cand_bin;
  logic [BITS-1:0]      delta;

  state_t               state, state_nxt;

  logic [BITS-1:0]      value_q,  value_nxt;
  logic                 valid_q,  valid_nxt;
  logic                 step_q,   step_nxt;
  logic                 dir_q,    dir_nxt;
  logic                 err_q,    err_nxt;
  logic [POS_W-1:0]     pos_q,    pos_nxt;

  // Until sync_fill is full the synchronizer output is not yet a real sample,
  // so the candidate is reloaded; this keeps post-reset latency equal to the
  // latency for any later input change.
  assign load   = !sync_fill[2] || (sync_s != cand);
  assign accept = (cnt == CNT_MAX) && !fired;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_1    <= '0;
      sync_s    <= '0;
      sync_fill <= '0;
      cand      <= '0;
      cnt       <= '0;
      fired     <= 1'b0;
    end else begin
      sync_1    <= bus.GRAY_IN;
      sync_s    <= sync_1;
      sync_fill <= {sync_fill[1:0], 1'b1};
      if (load) begin
        cand  <= sync_s;
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + FILT_LOG2'(1);
        end
        if (accept) begin
          fired <= 1'b1;
        end
      end
    end
  end

  assign cand_bin = gray2bin(cand);
  assign delta    = cand_bin - value_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (accept) state_nxt = ST_TRACK;
      ST_TRACK: state_nxt = ST_TRACK;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    value_nxt = value_q;
    valid_nxt = valid_q;
    step_nxt  = 1'b0;
    dir_nxt   = dir_q;
    err_nxt   = 1'b0;
    pos_nxt   = pos_q;
    case (state)
      ST_INIT: begin
        if (accept) begin
          value_nxt = cand_bin;
          valid_nxt = 1'b1;
        end
      end
      ST_TRACK: begin
        if (accept && (delta != '0)) begin
          value_nxt = cand_bin;
          if (delta == DELTA_UP) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b1;
            pos_nxt  = pos_q + POS_W'(1);
          end else if (delta == DELTA_DN) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b0;
            pos_nxt  = pos_q - POS_W'(1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_q <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      value_q <= value_nxt;
      valid_q <= valid_nxt;
      step_q  <= step_nxt;
      dir_q   <= dir_nxt;
      err_q   <= err_nxt;
      pos_q   <= pos_nxt;
    end
  end

  assign bus.VALUE    = value_q;
  assign bus.VALID    = valid_q;
  assign bus.STEP     = step_q;
  assign bus.DIR      = dir_q;
  assign bus.ERR      = err_q;
  assign bus.POSITION = pos_q;

endmodule

// File: doc/gray_in_decoder.md
Name: gray_in_decoder

Overview:
- Receive-side counterpart to the board's binary-to-Gray LED driver.
- Samples an asynchronous BITS-wide reflected-Gray code on input pins, from an absolute rotary encoder or a second board's LED header.
- Synchronizes and debounces the code, converts it to binary, and classifies each accepted change as an up step, a down step or a skip error.
- Maintains a signed relative position accumulator for downstream logic, for example to drive a counter like the LED demo.

Parameters:
- BITS, 5, width of the Gray code input and of VALUE.
- FILT_LOG2, 4, stability window: an input is accepted after 2**FILT_LOG2 consecutive identical synchronized samples; legal range 1..20.
- POS_W, 16, width of the POSITION accumulator (two's complement).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- GRAY_IN  in  BITS  asynchronous Gray-coded input pins.
- VALUE  out  BITS  binary equivalent of the last accepted code.
- VALID  out  1  high once the first code has been accepted since reset.
- STEP  out  1  one-cycle pulse when an accepted change is ±1.
- DIR  out  1  direction of the last STEP: 1 = up (+1), 0 = down (−1); holds its value between steps.
- ERR  out  1  one-cycle pulse when an accepted change is neither +1 nor −1.
- POSITION  out  POS_W  signed accumulated steps.

Behaviour:
- Reset (RST high at an edge):
  - Synchronizer flops, candidate register, filter counter, VALUE, VALID, STEP, DIR, ERR and POSITION all clear to 0.
  - State goes to INIT.
  - RST overrides everything, including a pending acceptance.
- Synchronizer: two flops per bit; only the second-stage output (S) is used downstream.
- Filter:
  - If S != candidate: candidate <= S and count <= 0.
  - Otherwise count increments, saturating at 2**FILT_LOG2−1.
  - An acceptance event fires in the cycle count reaches 2**FILT_LOG2−1, and fires only once per stable period.
  - Pulses on GRAY_IN shorter than 2**FILT_LOG2 cycles never produce an acceptance.
- Conversion: binary b[BITS−1] = g[BITS−1]; b[i] = b[i+1] XOR g[i]. Computed on the candidate.
- State INIT, on acceptance:
  - VALUE <= binary(candidate), VALID <= 1, go to TRACK.
  - No STEP or ERR pulse; POSITION unchanged.
  - Acceptance happens even when the code equals the post-reset candidate value 0.
- State TRACK, on acceptance, with delta = (new − VALUE) mod 2**BITS:
  - delta == 0: no change, no pulse (bounce that returned to the held code).
  - delta == 1: STEP=1, DIR=1, POSITION += 1.
  - delta == 2**BITS−1: STEP=1, DIR=0, POSITION −= 1.
  - Any other delta: ERR=1, STEP=0, POSITION unchanged.
  - In every nonzero case VALUE <= new.
- Wrap-around:
  - VALUE 2**BITS−1 → 0 is a +1 step; VALUE 0 → 2**BITS−1 is a −1 step.
  - POSITION wraps modulo 2**POS_W with no saturation and no flag.
- Pulses: STEP and ERR are never high together. Each is high for exactly the one cycle after the acceptance edge and low otherwise.
- Latency:
  - Suppose GRAY_IN settles to a new value before edge t and holds it.
  - The outputs reflect the new value after edge t + 2 + 2**FILT_LOG2, giving L = 2**FILT_LOG2 + 3 cycles from first sample to visible output (19 with the defaults).
  - The bench checks this exactly.
- Continuous changes faster than the stability window: no acceptance ever fires; outputs hold.

Test Plan:
- Scenarios use the defaults (BITS=5, FILT_LOG2=4, POS_W=16).
- Startup:
  - Stimulus: RST high for 2 cycles, then low; GRAY_IN=00000 held.
  - Required: VALID rises exactly 19 edges after the first post-reset sample; VALUE=0; STEP=ERR=0 throughout; POSITION=0.
- Up steps:
  - Stimulus: from VALUE=0, GRAY_IN 00001, then 00011, each held 32 cycles.
  - Required: two STEP pulses, each with DIR=1; VALUE 1, then 2; POSITION=2.
- Wrap:
  - Stimulus: from VALUE=0 and POSITION=0, apply 10000 (binary 31).
  - Required: STEP with DIR=0; VALUE=31; POSITION=16'hFFFF.
  - Stimulus: then apply 00000.
  - Required: STEP with DIR=1; VALUE=0; POSITION=0.
- Debounce:
  - Stimulus: stable 00001, then 00011 for 15 cycles, then back to 00001.
  - Required: no STEP or ERR; VALUE stays 1.
  - Stimulus: repeat with the 00011 pulse lasting 16+ cycles.
  - Required: STEP, VALUE=2.
- Skip error:
  - Stimulus: from VALUE=0 and POSITION=5, apply 00110 (binary 4).
  - Required: one ERR pulse; STEP=0; VALUE=4; POSITION stays 5.
- Reset mid-operation:
  - Stimulus: RST asserted while the filter count is at 10 and POSITION=3.
  - Required: next cycle all outputs are 0 and VALID=0; after release with an unchanged input, re-acceptance occurs with no STEP and POSITION=0.
